imem_program_loader: RTL
========================

// Module: imem_program_loader
// PURPOSE
//  Writer side of the instruction memory: takes a byte stream (valid/ready), packs it into
//  big-endian 32-bit MIPS words, and writes them to consecutive instruction-memory word addresses.
//  Holds the pipeline core in reset while loading and releases it once the image is complete.
//  Sits beside the fetch stage, which only reads instruction memory; this block owns its write port.
// PARAMETERS
//  DEPTH_WORDS  128  instruction-memory capacity in 32-bit words
//  ADDR_W       7    word-address width; must satisfy 2**ADDR_W >= DEPTH_WORDS
// PORTS
//  Clk        in   1         single clock, rising edge
//  Reset      in   1         asynchronous, active-high
//  Start      in   1         begin or restart a load (level sampled each cycle)
//  ByteIn     in   8         image byte, first byte = instruction bits [31:24]
//  ByteValid  in   1         ByteIn is valid
//  LastByte   in   1         qualifies ByteIn as the final byte of the image
//  ByteReady  out  1         loader accepts a byte this cycle
//  WrEn       out  1         one-cycle instruction-memory write strobe
//  WrAddr     out  ADDR_W    word address of the write
//  WrData     out  32        packed instruction word
//  CoreReset  out  1         holds the pipeline core in reset
//  Done       out  1         image loaded, core released
//  Error      out  1         partial final word or overflow; core stays held
//  WordCount  out  ADDR_W+1  number of words written in the current load
// BEHAVIOUR
//  - Reset values: ByteReady=0, WrEn=0, WrAddr=0, WrData=0, CoreReset=1, Done=0, Error=0,
//    WordCount=0, state=IDLE. Reset takes effect immediately and from any state.
//  - A byte transfers on a rising edge where ByteValid && ByteReady. ByteReady=1 only in COLLECT.
//  - States and transitions:
//    IDLE:    Start -> COLLECT (clears byte index and WordCount).
//    COLLECT: each accepted byte fills the word MSB-first (byte k goes to [31-8k -: 8]).
//             Acceptance of the 4th byte moves to WRITE.
//             LastByte on byte 1..3 -> ERROR, with no write.
//             Any byte accepted while WordCount==DEPTH_WORDS -> ERROR, with no write.
//    WRITE:   WrEn=1 for exactly one cycle, WrAddr=WordCount[ADDR_W-1:0], WrData=packed word.
//             WordCount increments at the end of this cycle.
//             If the 4th byte carried LastByte -> DONE, else -> COLLECT.
//             ByteReady=0 in this state; a pending valid byte is held by the source, never dropped.
//    DONE:    CoreReset=0, Done=1. Start -> COLLECT, with CoreReset=1 and Done=0 from the next cycle.
//    ERROR:   CoreReset=1, Error=1. Start -> COLLECT, with Error cleared.
//  - Latency: the 4th byte is accepted at edge N; WrEn is high during cycle N+1. Peak throughput
//    is 5 cycles per word.
//  - Start is ignored in COLLECT and WRITE.
//  - Memory contents are never cleared. A partial word lost to Reset or Error is discarded.
//  - All outputs are registered; there is no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared header loader_defs.vh: state encodings (IDLE, COLLECT, WRITE, DONE, ERROR) and
//    BYTES_PER_WORD=4.
//  - One sub-module, byte_packer: 2-bit byte index plus 32-bit MSB-first shift/assemble register,
//    with clear and load inputs.
//  - The FSM, WordCount and output registers live in the top-level block.
// TESTING
//  1. Reset, then Start, then stream 20 08 00 05 00 00 00 00 with LastByte on the 8th byte.
//     Expect WrEn pulses (addr 0, 0x20080005) and (addr 1, 0x00000000), then Done=1, CoreReset=0,
//     WordCount=2.
//  2. ByteValid held high continuously: ByteReady=0 in each WRITE cycle; the 5th byte is accepted
//     one cycle later and no byte is lost or duplicated.
//  3. LastByte on the 3rd byte (AA BB CC): expect Error=1, CoreReset=1, no WrEn.
//     Then Start plus 4 bytes: write at addr 0.
//  4. DEPTH_WORDS=4, 17 bytes without LastByte: expect 4 writes (addr 0..3); the 17th byte sets
//     Error=1 and WordCount stays 4.
//  5. Assert Reset after 6 bytes: all outputs take reset values in the same cycle.
//     Start plus 4 bytes 12 34 56 78: expect write at addr 0 with 0x12345678.
//  6. From DONE, pulse Start: CoreReset=1 and Done=0 next cycle, WordCount=0;
//     a new image overwrites from addr 0.

Source files
------------

// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Holds the state encodings, the byte/word geometry and the packer index width.
package imem_program_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = 2;

  // Loader FSM encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

endpackage

// File: rtl/imem_program_loader_byte_packer.sv
// Assembles four bytes into one big-endian 32-bit word, first byte in [31:24].
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clear           drop any partial word and restart at byte 0 (wins over i_load)
//   i_load            store i_byte at the current byte position and advance
//   i_byte            incoming byte
//   o_index           position the next loaded byte will take (0..3)
//   o_word            assembled word register
module imem_program_loader_byte_packer
  import imem_program_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [IDX_W-1:0]  o_index,
  output logic [WORD_W-1:0] o_word
);

  logic [IDX_W-1:0]  r_index;
  logic [WORD_W-1:0] r_word;

  // Byte lane selected by position; index wraps to 0 after the 4th byte
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_index <= '0;
      r_word  <= '0;
    end else if (i_clear) begin
      r_index <= '0;
      r_word  <= '0;
    end else if (i_load) begin
      case (r_index)
        2'd0:    r_word[31:24] <= i_byte;
        2'd1:    r_word[23:16] <= i_byte;
        2'd2:    r_word[15:8]  <= i_byte;
        default: r_word[7:0]   <= i_byte;
      endcase
      r_index <= r_index + IDX_W'(1);
    end
  end

  assign o_index = r_index;
  assign o_word  = r_word;

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory writer: packs a valid/ready byte stream into big-endian words,
// writes them to consecutive word addresses and holds the core in reset until the
// image is complete.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_start          begin/restart a load (honoured in IDLE, DONE, ERROR)
//   i_byte_in        image byte; i_byte_valid qualifies it, i_last_byte marks the final one
//   o_byte_ready     loader accepts a byte this cycle
//   o_wr_en          one-cycle write strobe with o_wr_addr / o_wr_data
//   o_core_reset     holds the pipeline core in reset
//   o_done           image loaded, core released
//   o_error          partial final word or overflow
//   o_word_count     words written in the current load
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [BYTE_W-1:0] i_byte_in,
  input  logic              i_byte_valid,
  input  logic              i_last_byte,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_core_reset,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int unsigned    CNT_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_byte_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_core_reset;
  logic              r_done;
  logic              r_error;
  logic [CNT_W-1:0]  r_word_count;
  logic              r_last_word;

  logic              w_accept;
  logic              w_pk_clear;
  logic              w_pk_load;
  logic              w_cnt_clear;
  logic [IDX_W-1:0]  w_pk_index;
  logic [WORD_W-1:0] w_pk_word;

  // Ready mirrors the COLLECT state, so acceptance needs only the registered ready
  assign w_accept = i_byte_valid & r_byte_ready;

  imem_program_loader_byte_packer u_packer (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_clear (w_pk_clear),
    .i_load  (w_pk_load),
    .i_byte  (i_byte_in),
    .o_index (w_pk_index),
    .o_word  (w_pk_word)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and packer/counter controls
  always_comb begin
    w_state_nxt = r_state;
    w_pk_clear  = 1'b0;
    w_pk_load   = 1'b0;
    w_cnt_clear = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          w_state_nxt = ST_COLLECT;
          w_pk_clear  = 1'b1;
          w_cnt_clear = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (w_accept) begin
          if (r_word_count == CNT_W'(DEPTH_WORDS)) begin
            // Memory already full: any further byte is an overflow
            w_state_nxt = ST_ERROR;
            w_pk_clear  = 1'b1;
          end else if (i_last_byte && (w_pk_index != LAST_IDX)) begin
            // Image ends mid-word
            w_state_nxt = ST_ERROR;
            w_pk_clear  = 1'b1;
          end else begin
            w_pk_load = 1'b1;
            if (w_pk_index == LAST_IDX) w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        w_state_nxt = r_last_word ? ST_DONE : ST_COLLECT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_last_word  <= 1'b0;
    end else begin
      r_byte_ready <= (w_state_nxt == ST_COLLECT);
      r_wr_en      <= (w_state_nxt == ST_WRITE);
      r_core_reset <= (w_state_nxt != ST_DONE);
      r_done       <= (w_state_nxt == ST_DONE);
      r_error      <= (w_state_nxt == ST_ERROR);

      if (w_cnt_clear)              r_word_count <= '0;
      else if (r_state == ST_WRITE) r_word_count <= r_word_count + CNT_W'(1);

      // Capture address and end-of-image flag as the 4th byte is accepted
      if ((r_state == ST_COLLECT) && (w_state_nxt == ST_WRITE)) begin
        r_wr_addr   <= r_word_count[ADDR_W-1:0];
        r_last_word <= i_last_byte;
      end
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = w_pk_word;
  assign o_core_reset = r_core_reset;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_word_count = r_word_count;

endmodule
